pixel_cluster_adc: RTL and testbench
====================================

// Module: pixel_cluster_adc
// PURPOSE
//  Synthesizable successor of the behavioural pixel sensor. CHANNELS pixels share one clocked
//  sequencer: erase, expose (integrate digital light), single-slope convert, sequential readout.
//  Sits between the top-level capture controller and the readout bus/FIFO; the analog model is
//  replaced by integer integrators, so the block runs in synthesis and simulation alike.
// PARAMETERS
//  PIXEL_BITS  8  width of light sample, ramp counter and output code
//  CHANNELS    4  number of pixels in the cluster (>=1)
//  EXP_SHIFT   8  extra integrator LSBs; ACC_W = PIXEL_BITS+EXP_SHIFT
// PORTS
//  clk            in   1                    clock, all state on rising edge
//  reset_n        in   1                    asynchronous, active-low reset
//  start          in   1                    begin capture; honoured in IDLE only
//  expose_cycles  in   16                   exposure length, sampled when start accepted
//  light          in   CHANNELS*PIXEL_BITS  per-pixel intensity, ch i at [i*PIXEL_BITS +: PIXEL_BITS]
//  busy           out  1                    high in any state except IDLE
//  done           out  1                    one-cycle pulse after last word transferred
//  out_valid      out  1                    readout word valid
//  out_ready      in   1                    consumer accepts word
//  out_data       out  PIXEL_BITS           latched code of current channel
//  out_chan       out  $clog2(CHANNELS)     channel index of out_data (width 1 when CHANNELS=1)
//  out_sat        out  1                    only with PIXEL_SAT_FLAG_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, out_valid, out_sat = 0; out_data, out_chan = 0; all accs,
//    latches and fired flags cleared. Reset mid-operation aborts immediately; no done pulse.
//  - FSM: IDLE -> ERASE -> EXPOSE -> CONVERT -> READOUT -> IDLE.
//  - IDLE: start=1 at edge k -> ERASE during cycle k+1. start outside IDLE ignored.
//  - ERASE (1 cycle): acc[i] = 2**ACC_W-1, fired[i]=0, code[i]=0, sat[i]=0, exp_cnt=0.
//  - EXPOSE: exactly expose_cycles cycles; each cycle acc[i] -= light[i] (zero-extended),
//    saturating at 0; reaching 0 sets sat[i]. expose_cycles==0 -> ERASE goes straight to CONVERT.
//  - CONVERT: exactly 2**PIXEL_BITS cycles, ramp r = 0..2**PIXEL_BITS-1 (wraps to 0 on exit).
//    top[i] = acc[i][ACC_W-1 -: PIXEL_BITS]. In cycle with ramp r: if !fired[i] && r >= top[i]
//    -> code[i]=r, fired[i]=1. Every pixel fires by r=max, so no code is left undefined.
//  - READOUT: out_valid=1 from first READOUT cycle; out_chan starts at 0, out_data=code[out_chan].
//    Transfer when out_valid&&out_ready; then out_chan+1. out_valid may not drop and out_data/
//    out_chan stay stable while out_ready=0. After transfer of channel CHANNELS-1: out_valid=0,
//    state=IDLE, done=1 for exactly one cycle, out_chan returns to 0.
//  - Zero-latency readout: out_ready held high -> one word per cycle, CHANNELS cycles total.
//  - light changing mid-EXPOSE is sampled every cycle (no hold required by consumer).
// CONFIGURATION
//  PIXEL_SAT_FLAG_EN defined: out_sat port exists; out_sat = sat[out_chan] while out_valid,
//    else 0; follows out_data handshake rules.
//  PIXEL_SAT_FLAG_EN undefined: port, sat registers and logic absent; out_data behaviour identical.
// TESTING
//  1 light all 0, expose_cycles=10, out_ready=1 -> 4 words, each 255, chan 0..3, done pulse, sat=0.
//  2 light ch0=255, expose=256 -> acc=255, top=0, ch0 code 0 (fires at r=0); other ch (light 0)=255.
//  3 light ch1=16, expose=16 -> acc=65279, ch1 code 254; expose_cycles=0 -> all codes 255.
//  4 light ch2=255, expose=300 -> acc saturates 0, code 0, out_sat=1 (macro on); port absent (off).
//  5 out_ready toggled 0/1 every 3 cycles -> out_data/out_chan stable while stalled, order 0..3,
//    no lost/duplicated words; start pulsed during CONVERT -> ignored, one done only.
//  6 reset_n low mid-CONVERT -> next cycle busy=0, out_valid=0; new start -> clean capture, case 1 values.

Source files
------------

// File: rtl/pixel_cluster_adc.sv
// Pixel cluster with shared erase/expose/single-slope-convert/readout sequencer.
// Optional macro PIXEL_SAT_FLAG_EN adds per-pixel saturation flags and the out_sat port.
module pixel_cluster_adc #(
  parameter int PIXEL_BITS = 8,
  parameter int CHANNELS   = 4,
  parameter int EXP_SHIFT  = 8,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [15:0]                    expose_cycles,
  input  logic [CHANNELS*PIXEL_BITS-1:0] light,
  output logic                           busy,
  output logic                           done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PIXEL_BITS-1:0]          out_data,
  output logic [CW-1:0]                  out_chan
`ifdef PIXEL_SAT_FLAG_EN
  ,
  output logic                           out_sat
`endif
);

  localparam int ACC_W = PIXEL_BITS + EXP_SHIFT;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_READOUT = 3'd4;

  localparam logic [CW-1:0]         LAST_CH  = CW'(CHANNELS - 1);
  localparam logic [PIXEL_BITS-1:0] RAMP_MAX = '1;

  logic [2:0]            r_state;
  logic [15:0]           r_exp_len;
  logic [15:0]           r_exp_cnt;
  logic [PIXEL_BITS-1:0] r_ramp;
  logic [ACC_W-1:0]      r_acc  [CHANNELS];
  logic [PIXEL_BITS-1:0] r_code [CHANNELS];
  logic [CHANNELS-1:0]   r_fired;
  logic [CW-1:0]         r_chan;
  logic                  r_done;
`ifdef PIXEL_SAT_FLAG_EN
  logic [CHANNELS-1:0]   r_sat;
`endif

  logic [ACC_W-1:0]      w_light  [CHANNELS];
  logic [ACC_W-1:0]      w_acc_nx [CHANNELS];
  logic [PIXEL_BITS-1:0] w_top    [CHANNELS];

  // Integrators discharge from full scale and clamp at zero.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_light[i]  = ACC_W'(light[i*PIXEL_BITS +: PIXEL_BITS]);
      w_acc_nx[i] = (r_acc[i] > w_light[i]) ? (r_acc[i] - w_light[i]) : '0;
      w_top[i]    = r_acc[i][ACC_W-1 -: PIXEL_BITS];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_exp_len <= '0;
      r_exp_cnt <= '0;
      r_ramp    <= '0;
      r_fired   <= '0;
      r_chan    <= '0;
      r_done    <= 1'b0;
`ifdef PIXEL_SAT_FLAG_EN
      r_sat     <= '0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i]  <= '0;
        r_code[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp_len <= expose_cycles;
            r_state   <= S_ERASE;
          end
        end
        S_ERASE: begin
          r_exp_cnt <= '0;
          r_ramp    <= '0;
          r_fired   <= '0;
`ifdef PIXEL_SAT_FLAG_EN
          r_sat     <= '0;
`endif
          for (int i = 0; i < CHANNELS; i++) begin
            r_acc[i]  <= '1;
            r_code[i] <= '0;
          end
          r_state <= (r_exp_len == 16'd0) ? S_CONVERT : S_EXPOSE;
        end
        S_EXPOSE: begin
          for (int i = 0; i < CHANNELS; i++) begin
            r_acc[i] <= w_acc_nx[i];
`ifdef PIXEL_SAT_FLAG_EN
            if (w_acc_nx[i] == '0)
              r_sat[i] <= 1'b1;
`endif
          end
          r_exp_cnt <= r_exp_cnt + 16'd1;
          if (r_exp_cnt == r_exp_len - 16'd1)
            r_state <= S_CONVERT;
        end
        S_CONVERT: begin
          // First ramp value at or above the integrator top bits becomes the code.
          for (int i = 0; i < CHANNELS; i++) begin
            if (!r_fired[i] && (r_ramp >= w_top[i])) begin
              r_code[i]  <= r_ramp;
              r_fired[i] <= 1'b1;
            end
          end
          r_ramp <= r_ramp + 1'b1;
          if (r_ramp == RAMP_MAX)
            r_state <= S_READOUT;
        end
        S_READOUT: begin
          if (out_ready) begin
            if (r_chan == LAST_CH) begin
              r_chan  <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_chan <= r_chan + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign out_valid = (r_state == S_READOUT);
  assign out_data  = r_code[r_chan];
  assign out_chan  = r_chan;
`ifdef PIXEL_SAT_FLAG_EN
  assign out_sat   = out_valid & r_sat[r_chan];
`endif

endmodule

// File: tb/tb_pixel_cluster_adc.sv
// Self-checking bench for pixel_cluster_adc: directed cases plus randomized
// exposures checked against an arithmetic integrate-and-quantize model.
module tb_pixel_cluster_adc;

  localparam int PB = 8;
  localparam int CH = 4;
  localparam int ES = 8;
  localparam int FULL = (1 << (PB + ES)) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   expose_cycles = '0;
  logic [CH*PB-1:0] light = '0;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PB-1:0] out_data;
  logic [1:0]    out_chan;
`ifdef PIXEL_SAT_FLAG_EN
  logic          out_sat;
`endif

  int vectors = 0;
  int miscompares = 0;

  pixel_cluster_adc #(
    .PIXEL_BITS(PB),
    .CHANNELS(CH),
    .EXP_SHIFT(ES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .expose_cycles(expose_cycles),
    .light(light),
    .busy(busy),
    .done(done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_chan(out_chan)
`ifdef PIXEL_SAT_FLAG_EN
    ,
    .out_sat(out_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full capture. Model: each pixel integrates down from full scale,
  // clamping at 0; its code is the integrator's top PB bits.
  task automatic capture(input int ex, input logic [31:0] lf,
                         input bit rnd, input bit stall,
                         input bit poke, input bit abort);
    int acc [CH];
    int idx;
    int cyc;
    int l;
    for (int i = 0; i < CH; i++) acc[i] = FULL;
    light = lf;
    expose_cycles = 16'(ex);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    for (int c = 0; c < ex; c++) begin
      if (rnd) light = $urandom;
      for (int i = 0; i < CH; i++) begin
        l = int'(light[i*PB +: PB]);
        acc[i] = (acc[i] > l) ? acc[i] - l : 0;
      end
      @(negedge clk);
    end
    for (int c = 0; c < (1 << PB); c++) begin
      if (c == 0 || c == (1 << PB) - 1) begin
        chk("convert_busy", {31'd0, busy}, 32'd1);
        chk("convert_valid", {31'd0, out_valid}, 32'd0);
      end
      start = (poke && c == 100);
      if (abort && c == 50) begin
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("abort_busy2", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < CH && cyc < 64) begin
      chk("rd_valid", {31'd0, out_valid}, 32'd1);
      chk("rd_chan", {30'd0, out_chan}, 32'(idx));
      chk("rd_data", {24'd0, out_data}, 32'(acc[idx] >> ES));
`ifdef PIXEL_SAT_FLAG_EN
      chk("rd_sat", {31'd0, out_sat}, {31'd0, acc[idx] == 0});
`endif
      out_ready = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
      @(negedge clk);
      if (out_ready) idx++;
      cyc++;
    end
    chk("rd_complete", 32'(idx), 32'(CH));
    if (!stall) chk("rd_cycles", 32'(cyc), 32'(CH));
    out_ready = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("end_valid", {31'd0, out_valid}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_chan", {30'd0, out_chan}, 32'd0);
`ifdef PIXEL_SAT_FLAG_EN
    chk("end_sat", {31'd0, out_sat}, 32'd0);
`endif
    @(negedge clk);
    chk("done_once", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_chan", {30'd0, out_chan}, 32'd0);
`ifdef PIXEL_SAT_FLAG_EN
    chk("rst_sat", {31'd0, out_sat}, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // start ignored while held low; idle stays idle
    chk("idle_quiet", {31'd0, busy}, 32'd0);

    capture(10, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(256, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(16, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(300, 32'h00FF_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(20, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
    capture(40, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    capture(10, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++)
      capture(int'($urandom_range(0, 400)), $urandom, 1'b1,
              1'($urandom_range(0, 1)), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
